sobel_frame_sequencer: RTL and testbench

SOBEL_FRAME_SEQUENCER -- requirements
Module: sobel_frame_sequencer

---
 rtl/sobel_pkg.sv | 12 +
 rtl/sobel_valid_delay.sv | 34 +++
 rtl/sobel_frame_sequencer.sv | 129 ++++++++++++
 tb/tb_sobel_frame_sequencer.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// Shared definitions for the Sobel frame sequencer: FSM encoding and default pipe latency.
package sobel_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } seq_state_e;

  localparam int SOBEL_PIPE_LAT = 3;

endpackage

// File: rtl/sobel_valid_delay.sv
// Delay line that aligns result-valid and centre-row index with the Sobel array output.
module sobel_valid_delay #(
  parameter int ROW_AW = 10,
  parameter int DEPTH  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid_i,
  input  logic [ROW_AW-1:0] in_row_i,
  output logic              out_valid_o,
  output logic [ROW_AW-1:0] out_row_o
);

  logic [DEPTH-1:0]  vld_q;
  logic [ROW_AW-1:0] row_q [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int i = 0; i < DEPTH; i++) row_q[i] <= '0;
    end else begin
      vld_q[0] <= in_valid_i;
      row_q[0] <= in_row_i;
      for (int i = 1; i < DEPTH; i++) begin
        vld_q[i] <= vld_q[i-1];
        row_q[i] <= row_q[i-1];
      end
    end
  end

  assign out_valid_o = vld_q[DEPTH-1];
  assign out_row_o   = row_q[DEPTH-1];

endmodule

// File: rtl/sobel_frame_sequencer.sv
// Walks a frame of N rows through the Sobel array: top pad, N memory reads, bottom pad,
// then waits for the last result row before pulsing done.
module sobel_frame_sequencer
  import sobel_pkg::*;
#(
  parameter int ROW_AW   = 10,
  parameter int PIPE_LAT = SOBEL_PIPE_LAT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ROW_AW-1:0] cfg_rows,
  output logic              busy,
  output logic              done,
  output logic              cfg_err,
  output logic              row_rd_en,
  output logic [ROW_AW-1:0] row_rd_addr,
  output logic              in_valid,
  output logic              in_zero,
  output logic              out_valid,
  output logic [ROW_AW-1:0] out_row,
  output seq_state_e        dbg_state_o
);

  localparam int CW = ROW_AW + 1;

  seq_state_e        state_q, state_d;
  logic [CW-1:0]     slot_q, slot_d;
  logic [ROW_AW-1:0] rows_q, rows_d;
  logic              cfg_err_q, cfg_err_d;
  logic              done_q, done_d;
  logic              in_valid_q, in_valid_d;
  logic              in_zero_q, in_zero_d;
  logic              ctr_valid_q, ctr_valid_d;
  logic [ROW_AW-1:0] ctr_row_q, ctr_row_d;

  logic [CW-1:0]     last_slot, slot_m1, slot_m2;
  logic              accept, last_out, is_read, dl_valid;
  logic [ROW_AW-1:0] dl_row;

  // Slot counter is one bit wider than a row index so slot N+1 never wraps.
  assign last_slot = {1'b0, rows_q} + CW'(1);
  assign slot_m1   = slot_q - CW'(1);
  assign slot_m2   = slot_q - CW'(2);
  assign accept    = (state_q == ST_IDLE) && start;
  assign is_read   = (state_q == ST_ISSUE) && (slot_q != '0) && (slot_q != last_slot);
  assign last_out  = (state_q == ST_DRAIN) && dl_valid && (dl_row == rows_q - ROW_AW'(1));

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept && (cfg_rows != '0)) state_d = ST_ISSUE;
      ST_ISSUE: if (slot_q == last_slot)        state_d = ST_DRAIN;
      ST_DRAIN: if (last_out)                   state_d = ST_IDLE;
      default:                                  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    slot_d      = slot_q;
    rows_d      = rows_q;
    cfg_err_d   = accept && (cfg_rows == '0);
    done_d      = last_out;
    in_valid_d  = (state_q == ST_ISSUE);
    in_zero_d   = (state_q == ST_ISSUE) && ((slot_q == '0) || (slot_q == last_slot));
    ctr_valid_d = (state_q == ST_ISSUE) && (slot_q >= CW'(2));
    ctr_row_d   = ctr_valid_d ? slot_m2[ROW_AW-1:0] : '0;
    if (state_q == ST_IDLE) begin
      slot_d = '0;
      if (accept && (cfg_rows != '0)) rows_d = cfg_rows;
    end else if ((state_q == ST_ISSUE) && (slot_q != last_slot)) begin
      slot_d = slot_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_q      <= '0;
      rows_q      <= '0;
      cfg_err_q   <= 1'b0;
      done_q      <= 1'b0;
      in_valid_q  <= 1'b0;
      in_zero_q   <= 1'b0;
      ctr_valid_q <= 1'b0;
      ctr_row_q   <= '0;
    end else begin
      slot_q      <= slot_d;
      rows_q      <= rows_d;
      cfg_err_q   <= cfg_err_d;
      done_q      <= done_d;
      in_valid_q  <= in_valid_d;
      in_zero_q   <= in_zero_d;
      ctr_valid_q <= ctr_valid_d;
      ctr_row_q   <= ctr_row_d;
    end
  end

  // ctr_* is aligned with in_valid, so PIPE_LAT further stages land on the array output.
  sobel_valid_delay #(
    .ROW_AW (ROW_AW),
    .DEPTH  (PIPE_LAT)
  ) u_valid_delay (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (ctr_valid_q),
    .in_row_i    (ctr_row_q),
    .out_valid_o (dl_valid),
    .out_row_o   (dl_row)
  );

  always_comb begin
    busy        = (state_q != ST_IDLE);
    done        = done_q;
    cfg_err     = cfg_err_q;
    row_rd_en   = is_read;
    row_rd_addr = is_read ? slot_m1[ROW_AW-1:0] : '0;
    in_valid    = in_valid_q;
    in_zero     = in_zero_q;
    out_valid   = dl_valid;
    out_row     = dl_row;
    dbg_state_o = state_q;
  end

endmodule

// File: tb/tb_sobel_frame_sequencer.sv
// Directed bench for sobel_frame_sequencer: per-cycle vector table plus a full-height frame.
module tb_sobel_frame_sequencer;
  import sobel_pkg::*;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] cfg_rows;
  logic          busy, done, cfg_err, row_rd_en, in_valid, in_zero, out_valid;
  logic [AW-1:0] row_rd_addr, out_row;
  seq_state_e    dbg_state;

  int checks = 0;
  int errors = 0;

  // Valid/ready note: this block has no back-pressure; every strobe is a single-cycle
  // qualifier and the bench samples all outputs on the falling edge.
  typedef struct {
    logic          rst_n;
    logic          start;
    logic [AW-1:0] rows;
    logic [26:0]   exp;
  } vec_t;

  vec_t          vec_q[$];
  logic [AW-1:0] exp_q[$];

  sobel_frame_sequencer #(.ROW_AW(AW), .PIPE_LAT(3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .cfg_rows    (cfg_rows),
    .busy        (busy),
    .done        (done),
    .cfg_err     (cfg_err),
    .row_rd_en   (row_rd_en),
    .row_rd_addr (row_rd_addr),
    .in_valid    (in_valid),
    .in_zero     (in_zero),
    .out_valid   (out_valid),
    .out_row     (out_row),
    .dbg_state_o (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // r s rows | busy done err rd addr iv iz ov orow
  task automatic add(input logic r, input logic s, input int rows,
                     input logic b, input logic d, input logic e, input logic rd,
                     input int a, input logic iv, input logic iz, input logic ov,
                     input int orow);
    vec_t v;
    v.rst_n = r;
    v.start = s;
    v.rows  = AW'(rows);
    v.exp   = {b, d, e, rd, AW'(a), iv, iz, ov, AW'(orow)};
    vec_q.push_back(v);
  endtask

  task automatic add_n4_frame();
    add(1,1,4, 0,0,0,0,0, 0,0,0,0);
    add(1,0,7, 1,0,0,0,0, 0,0,0,0);
    add(1,0,7, 1,0,0,1,0, 1,1,0,0);
    add(1,0,7, 1,0,0,1,1, 1,0,0,0);
    add(1,0,7, 1,0,0,1,2, 1,0,0,0);
    add(1,1,7, 1,0,0,1,3, 1,0,0,0);
    add(1,0,7, 1,0,0,0,0, 1,0,0,0);
    add(1,0,7, 1,0,0,0,0, 1,1,1,0);
    add(1,1,0, 1,0,0,0,0, 0,0,1,1);
    add(1,0,0, 1,0,0,0,0, 0,0,1,2);
    add(1,0,0, 1,0,0,0,0, 0,0,1,3);
    add(1,0,0, 0,1,0,0,0, 0,0,0,0);
    add(1,0,0, 0,0,0,0,0, 0,0,0,0);
  endtask

  // Cycles 1..8 of an N=2 frame, start held high throughout.
  task automatic add_n2_body();
    add(1,1,2, 1,0,0,0,0, 0,0,0,0);
    add(1,1,2, 1,0,0,1,0, 1,1,0,0);
    add(1,1,2, 1,0,0,1,1, 1,0,0,0);
    add(1,1,2, 1,0,0,0,0, 1,0,0,0);
    add(1,1,2, 1,0,0,0,0, 1,1,0,0);
    add(1,1,2, 1,0,0,0,0, 0,0,0,0);
    add(1,1,2, 1,0,0,0,0, 0,0,1,0);
    add(1,1,2, 1,0,0,0,0, 0,0,1,1);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int            rd_cnt;
    int            rd_bad;
    int            done_cyc;
    int            cyc;
    logic [AW-1:0] e;

    // Basic N=4 frame with mid-frame cfg_rows change and stray starts.
    add_n4_frame();
    // cfg_rows == 0: error pulse only.
    add(1,1,0, 0,0,0,0,0, 0,0,0,0);
    add(1,0,0, 0,0,1,0,0, 0,0,0,0);
    add(1,0,0, 0,0,0,0,0, 0,0,0,0);
    // N=1: pad, row 0, pad.
    add(1,1,1, 0,0,0,0,0, 0,0,0,0);
    add(1,0,1, 1,0,0,0,0, 0,0,0,0);
    add(1,0,1, 1,0,0,1,0, 1,1,0,0);
    add(1,0,1, 1,0,0,0,0, 1,0,0,0);
    add(1,0,1, 1,0,0,0,0, 1,1,0,0);
    add(1,0,1, 1,0,0,0,0, 0,0,0,0);
    add(1,0,1, 1,0,0,0,0, 0,0,0,0);
    add(1,0,1, 1,0,0,0,0, 0,0,1,0);
    add(1,0,1, 0,1,0,0,0, 0,0,0,0);
    add(1,0,1, 0,0,0,0,0, 0,0,0,0);
    // Reset at cycle 5 of an N=4 frame, then a clean frame.
    add(1,1,4, 0,0,0,0,0, 0,0,0,0);
    add(1,0,4, 1,0,0,0,0, 0,0,0,0);
    add(1,0,4, 1,0,0,1,0, 1,1,0,0);
    add(1,0,4, 1,0,0,1,1, 1,0,0,0);
    add(1,0,4, 1,0,0,1,2, 1,0,0,0);
    add(0,0,4, 1,0,0,1,3, 1,0,0,0);
    for (int i = 0; i < 7; i++) add(1,0,4, 0,0,0,0,0, 0,0,0,0);
    add_n4_frame();
    // Back-to-back N=2 frames with start held high.
    add(1,1,2, 0,0,0,0,0, 0,0,0,0);
    add_n2_body();
    add(1,1,2, 0,1,0,0,0, 0,0,0,0);
    add_n2_body();
    add(1,0,2, 0,1,0,0,0, 0,0,0,0);
    add(1,0,2, 0,0,0,0,0, 0,0,0,0);

    rst_n    = 1'b0;
    start    = 1'b0;
    cfg_rows = '0;
    repeat (3) next_cycle();
    @(negedge clk);
    check("reset_outputs", 64'({busy, done, cfg_err, row_rd_en, row_rd_addr,
                                in_valid, in_zero, out_valid, out_row}), 64'd0);
    check("reset_state", 64'(dbg_state), 64'(ST_IDLE));
    next_cycle();

    for (int i = 0; i < vec_q.size(); i++) begin
      rst_n    = vec_q[i].rst_n;
      start    = vec_q[i].start;
      cfg_rows = vec_q[i].rows;
      @(negedge clk);
      check($sformatf("vec%0d", i),
            64'({busy, done, cfg_err, row_rd_en, row_rd_addr,
                 in_valid, in_zero, out_valid, out_row}),
            64'(vec_q[i].exp));
      next_cycle();
    end

    // Full-height frame: N = 2^AW - 1, done expected at cycle N+7.
    rst_n    = 1'b1;
    start    = 1'b1;
    cfg_rows = AW'(1023);
    for (int r = 0; r < 1023; r++) exp_q.push_back(AW'(r));
    rd_cnt   = 0;
    rd_bad   = 0;
    done_cyc = -1;
    cyc      = 0;
    while (cyc < 1100 && done_cyc < 0) begin
      @(negedge clk);
      if (row_rd_en) begin
        if (row_rd_addr !== AW'(rd_cnt)) rd_bad++;
        rd_cnt++;
      end
      if (out_valid) begin
        if (exp_q.size() == 0) check("big_extra_out", 64'd1, 64'd0);
        else begin
          e = exp_q.pop_front();
          check("big_out_row", 64'(out_row), 64'(e));
        end
      end
      if (cyc == 1)    check("big_state_issue", 64'(dbg_state), 64'(ST_ISSUE));
      if (cyc == 1026) check("big_state_drain", 64'(dbg_state), 64'(ST_DRAIN));
      if (done) done_cyc = cyc;
      next_cycle();
      start = 1'b0;
      cyc++;
    end
    check("big_done_cycle", 64'(done_cyc), 64'(1030));
    check("big_rd_count", 64'(rd_cnt), 64'(1023));
    check("big_rd_addr_seq", 64'(rd_bad), 64'd0);
    check("big_out_left", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
